// File: rtl/fft_pkg.sv
// Shared constants for the 8-point FFT output stage.
// Also hosts the alpha-max-beta-min helper used when FFT8_OUT_MAG_EN is set.
package fft_pkg;

  localparam int FFT_N    = 8;
  localparam int IN_W     = 67;
  localparam int IN_FRAC  = 42;
  localparam int OUT_W    = 32;
  localparam int OUT_FRAC = 14;
  localparam int IDX_W    = 3;
  localparam int SHIFT    = IN_FRAC - OUT_FRAC;
  localparam int MAG_W    = OUT_W + 1;

  // max(|re|,|im|) + min(|re|,|im|)/2; |0x80000000| reads as 2^31
  function automatic logic [MAG_W-1:0] amax_bmin(
    input logic [OUT_W-1:0] re,
    input logic [OUT_W-1:0] im
  );
    logic [OUT_W-1:0] ar;
    logic [OUT_W-1:0] ai;
    logic [OUT_W-1:0] mx;
    logic [OUT_W-1:0] mn;
    ar = re[OUT_W-1] ? (~re + 1'b1) : re;
    ai = im[OUT_W-1] ? (~im + 1'b1) : im;
    mx = (ar > ai) ? ar : ai;
    mn = (ar > ai) ? ai : ar;
    return {1'b0, mx} + {2'b00, mn[OUT_W-1:1]};
  endfunction

endpackage

// File: rtl/fft_round_sat.sv
// Round-half-up by SHIFT bits, then clamp to a signed OUT_W word.
// Pure combinational; one instance per real/imag value.
module fft_round_sat
  import fft_pkg::*;
(
  input  logic [IN_W-1:0]  x_i,
  output logic [OUT_W-1:0] y_o,
  output logic             sat_o
);

  localparam int RW = IN_W - SHIFT + 1;

  logic [RW-1:0] r;
  logic          pos_ovf;
  logic          neg_ovf;
  logic          unused_lo;

  // adding 2^(SHIFT-1) then truncating == upper bits + bit (SHIFT-1)
  assign r = {x_i[IN_W-1], x_i[IN_W-1:SHIFT]}
           + RW'(x_i[SHIFT-1]);

  assign unused_lo = ^x_i[SHIFT-2:0];

  assign pos_ovf = !r[RW-1] && (|r[RW-2:OUT_W-1]);
  assign neg_ovf = r[RW-1] && !(&r[RW-2:OUT_W-1]);

  // clamp to the nearest representable extreme
  always_comb begin
    y_o = r[OUT_W-1:0];
    if (pos_ovf) y_o = {1'b0, {(OUT_W-1){1'b1}}};
    if (neg_ovf) y_o = {1'b1, {(OUT_W-1){1'b0}}};
  end

  assign sat_o = pos_ovf | neg_ovf;

endmodule

// File: rtl/fft8_output_buffer.sv
// FFT8 output stage: round/saturate a frame, ping-pong buffer, stream bins.
// Optional FFT8_OUT_MAG_EN adds a stored per-bin magnitude estimate.
module fft8_output_buffer
  import fft_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FFT_N*IN_W-1:0] in_real,
  input  logic [FFT_N*IN_W-1:0] in_imag,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef FFT8_OUT_MAG_EN
  output logic [MAG_W-1:0]      out_mag,
`endif
  output logic [OUT_W-1:0]      out_real,
  output logic [OUT_W-1:0]      out_imag,
  output logic [IDX_W-1:0]      out_index,
  output logic                  out_last,
  output logic                  out_sat
);

  logic [OUT_W-1:0] rr [FFT_N];
  logic [OUT_W-1:0] ri [FFT_N];
  logic             sr [FFT_N];
  logic             si [FFT_N];

  logic [OUT_W-1:0] re_q [2][FFT_N];
  logic [OUT_W-1:0] im_q [2][FFT_N];
  logic             sr_q [2][FFT_N];
  logic             si_q [2][FFT_N];
`ifdef FFT8_OUT_MAG_EN
  logic [MAG_W-1:0] mg   [FFT_N];
  logic [MAG_W-1:0] mg_q [2][FFT_N];
`endif

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;

  logic wr_en;
  logic rd_en;
  logic rd_last;

  for (genvar k = 0; k < FFT_N; k++) begin : g_rs
    fft_round_sat u_re (
      .x_i   (in_real[k*IN_W +: IN_W]),
      .y_o   (rr[k]),
      .sat_o (sr[k])
    );
    fft_round_sat u_im (
      .x_i   (in_imag[k*IN_W +: IN_W]),
      .y_o   (ri[k]),
      .sat_o (si[k])
    );
`ifdef FFT8_OUT_MAG_EN
    assign mg[k] = amax_bmin(rr[k], ri[k]);
`endif
  end

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign wr_en     = in_valid && in_ready;
  assign rd_en     = out_valid && out_ready;
  assign rd_last   = rd_idx_q == IDX_W'(FFT_N-1);

  assign out_real  = re_q[rd_bank_q][rd_idx_q];
  assign out_imag  = im_q[rd_bank_q][rd_idx_q];
  assign out_sat   = sr_q[rd_bank_q][rd_idx_q]
                   | si_q[rd_bank_q][rd_idx_q];
  assign out_index = rd_idx_q;
  assign out_last  = out_valid && rd_last;
`ifdef FFT8_OUT_MAG_EN
  assign out_mag   = mg_q[rd_bank_q][rd_idx_q];
`endif

  // bank bookkeeping: free a drained read bank, claim the write bank
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    if (rd_en) begin
      rd_idx_d = rd_idx_q + 1'b1;
      if (rd_last) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
    if (wr_en) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
  end

  // control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  // frame storage: whole frame lands in the write bank in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < FFT_N; k++) begin
          re_q[b][k] <= '0;
          im_q[b][k] <= '0;
          sr_q[b][k] <= 1'b0;
          si_q[b][k] <= 1'b0;
`ifdef FFT8_OUT_MAG_EN
          mg_q[b][k] <= '0;
`endif
        end
      end
    end else if (wr_en) begin
      for (int k = 0; k < FFT_N; k++) begin
        re_q[wr_bank_q][k] <= rr[k];
        im_q[wr_bank_q][k] <= ri[k];
        sr_q[wr_bank_q][k] <= sr[k];
        si_q[wr_bank_q][k] <= si[k];
`ifdef FFT8_OUT_MAG_EN
        mg_q[wr_bank_q][k] <= mg[k];
`endif
      end
    end
  end

endmodule

// File: tb/tb_fft8_output_buffer.sv
// Bench for fft8_output_buffer: queue model + directed literal frames.
// Checks out_mag too when FFT8_OUT_MAG_EN is defined.
module tb_fft8_output_buffer;
  import fft_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [FFT_N*IN_W-1:0] in_real = '0;
  logic [FFT_N*IN_W-1:0] in_imag = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [OUT_W-1:0]      out_real;
  logic [OUT_W-1:0]      out_imag;
  logic [IDX_W-1:0]      out_index;
  logic                  out_last;
  logic                  out_sat;
`ifdef FFT8_OUT_MAG_EN
  logic [MAG_W-1:0]      out_mag;
`endif

  fft8_output_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef FFT8_OUT_MAG_EN
    .out_mag   (out_mag),
`endif
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_index (out_index),
    .out_last  (out_last),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
    logic [2:0]  idx;
    logic        sat;
    logic [32:0] mag;
  } bin_t;

  bin_t q[$];
  int   total = 0;
  int   bad = 0;
  int   rmode = 0;

  logic signed [IN_W-1:0] fr_re [8];
  logic signed [IN_W-1:0] fr_im [8];
  logic [31:0] ex_re [8];
  logic [31:0] ex_im [8];
  logic        ex_sat [8];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // returns {sat, value}: floor((x + 2^27) / 2^28), clamped to int32
  function automatic logic [32:0] rs_model(input logic signed [IN_W-1:0] x);
    logic signed [79:0] v;
    v = x;
    v = v + 80'sd134217728;
    v = v >>> 28;
    if (v > 80'sd2147483647) return {1'b1, 32'h7FFFFFFF};
    if (v < -80'sd2147483648) return {1'b1, 32'h80000000};
    return {1'b0, v[31:0]};
  endfunction

  function automatic logic [32:0] mag_model(input logic [31:0] re,
                                            input logic [31:0] im);
    longint a;
    longint b;
    longint mx;
    longint mn;
    a = longint'($signed(re));
    b = longint'($signed(im));
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return 33'(mx + mn / 2);
  endfunction

  logic        stall_q = 1'b0;
  logic [67:0] prev = '0;

  // per-cycle compare against the queue model
  always @(negedge clk) begin
    bin_t e;
    int   nfr;
    logic [32:0] a;
    logic [32:0] b;
    if (!rst_n) begin
      q.delete();
      stall_q = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_real", out_real, 0);
      chk("rst_out_imag", out_imag, 0);
      chk("rst_out_index", out_index, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_sat", out_sat, 0);
    end else begin
      nfr = (q.size() + 7) / 8;
      chk("in_ready", in_ready, 64'(nfr < 2));
      chk("out_valid", out_valid, 64'(q.size() != 0));
      if (q.size() != 0 && out_valid) begin
        e = q[0];
        chk("out_real", out_real, e.re);
        chk("out_imag", out_imag, e.im);
        chk("out_index", out_index, e.idx);
        chk("out_last", out_last, 64'(e.idx == 3'd7));
        chk("out_sat", out_sat, e.sat);
`ifdef FFT8_OUT_MAG_EN
        chk("out_mag", out_mag, e.mag);
`endif
      end else begin
        chk("idle_last", out_last, 0);
      end
      if (stall_q)
        chk("hold_stable", {out_real, out_imag, out_index, out_sat},
            prev);
      stall_q = out_valid && !out_ready;
      prev = {out_real, out_imag, out_index, out_sat};
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        for (int k = 0; k < 8; k++) begin
          a = rs_model(in_real[k*IN_W +: IN_W]);
          b = rs_model(in_imag[k*IN_W +: IN_W]);
          e.re  = a[31:0];
          e.im  = b[31:0];
          e.idx = 3'(k);
          e.sat = a[32] | b[32];
          e.mag = mag_model(a[31:0], b[31:0]);
          q.push_back(e);
        end
      end
    end
  end

  // downstream ready pattern
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic send_frame();
    int n;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      in_real[k*IN_W +: IN_W] = fr_re[k];
      in_imag[k*IN_W +: IN_W] = fr_im[k];
    end
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n >= 500) begin
        total++;
        bad++;
        $display("FAIL send_timeout act=stuck exp=accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_lit(input string tag);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk({tag, "_idx"}, out_index, 64'(k));
      chk({tag, "_real"}, out_real, ex_re[k]);
      chk({tag, "_imag"}, out_imag, ex_im[k]);
      chk({tag, "_sat"}, out_sat, ex_sat[k]);
      chk({tag, "_last"}, out_last, 64'(k == 7));
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (q.size() != 0 || out_valid) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        total++;
        bad++;
        $display("FAIL drain_timeout act=%0d exp=0", q.size());
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic basic_frame();
    for (int k = 0; k < 8; k++) begin
      fr_re[k]  = IN_W'(k) << 42;
      fr_im[k]  = -(IN_W'(k) << 42);
      ex_re[k]  = 32'(k * 16384);
      ex_im[k]  = 32'(-(k * 16384));
      ex_sat[k] = 1'b0;
    end
  endtask

  initial begin
    logic [32:0] p;
    int n;
    p = rs_model(67'sd1 << 27);
    chk("pin_half_up", p, {1'b0, 32'd1});
    p = rs_model(-(67'sd1 << 27));
    chk("pin_neg_half", p, {1'b0, 32'd0});
    p = rs_model(67'sd1 << 60);
    chk("pin_sat_pos", p, {1'b1, 32'h7FFFFFFF});
    p = mag_model(32'h80000000, 32'd2);
    chk("pin_mag_min", p, 33'h080000001);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rmode = 0;
    repeat (2) @(posedge clk);
    #1;

    basic_frame();
    send_frame();
    check_lit("basic");
    wait_empty();

    for (int k = 0; k < 8; k++) begin
      fr_re[k]  = '0;
      fr_im[k]  = '0;
      ex_re[k]  = '0;
      ex_im[k]  = '0;
      ex_sat[k] = 1'b0;
    end
    fr_re[0] = 67'sd1 << 27;
    ex_re[0] = 32'd1;
    fr_re[1] = -(67'sd1 << 27);
    ex_re[1] = 32'd0;
    fr_re[2] = 67'sd3 << 27;
    ex_re[2] = 32'd2;
    fr_re[3] = (67'sd1 << 27) - 67'sd1;
    ex_re[3] = 32'd0;
    fr_re[4] = 67'sd1 << 60;
    fr_im[4] = 67'sd1 << 66;
    ex_re[4] = 32'h7FFFFFFF;
    ex_im[4] = 32'h80000000;
    ex_sat[4] = 1'b1;
    send_frame();
    check_lit("rndsat");
    wait_empty();

    rmode = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) begin
        fr_re[k] = IN_W'(f * 8 + k + 1) << 42;
        fr_im[k] = -(IN_W'(f * 8 + k + 1) << 40);
      end
      if (f == 2) begin
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        fork
          begin
            repeat (6) @(posedge clk);
            rmode = 0;
          end
        join_none
      end
      send_frame();
    end
    wait_empty();

    rmode = 2;
    for (int f = 0; f < 50; f++) begin
      for (int k = 0; k < 8; k++) begin
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        fr_re[k] = $signed(t[IN_W-1:0]) >>> $urandom_range(0, 40);
        t = {$urandom, $urandom, $urandom};
        fr_im[k] = $signed(t[IN_W-1:0]) >>> $urandom_range(0, 40);
        if ($urandom_range(0, 3) == 0) fr_re[k][27:0] = 28'h8000000;
      end
      send_frame();
    end
    rmode = 0;
    wait_empty();

    basic_frame();
    send_frame();
    n = 0;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready && out_index == 3'd3) break;
      n++;
      if (n > 100) begin
        total++;
        bad++;
        $display("FAIL bin3_timeout act=%0d exp=3", out_index);
        break;
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_real", out_real, 0);
    chk("mid_rst_index", out_index, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    basic_frame();
    send_frame();
    check_lit("post_rst");
    wait_empty();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
